// File: rtl/multdiv_pkg.sv
// Shared types and constants for the mult/div sequencer.
package multdiv_pkg;

  localparam int unsigned CNT_W        = 6;
  localparam int unsigned MULT_LAT_DEF = 33;
  localparam int unsigned DIV_LAT_DEF  = 33;

  typedef enum logic [1:0] {
    IDLE,
    MULT_RUN,
    DIV_RUN,
    DONE
  } state_t;

  typedef enum logic {
    OP_MULT,
    OP_DIV
  } op_t;

  // Counter preload for a datapath latency: the zero count is the last RUN cycle.
  function automatic logic [CNT_W-1:0] latLoad(input int unsigned lat);
    return CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/multdiv_cnt.sv
// Loadable down-counter used to time datapath iterations; holds at zero.
module multdiv_cnt
  import multdiv_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] loadVal,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // Load has priority; decrement only while enabled and never below zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= loadVal;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequencer between the mult/div request interface and the iterative datapaths.
module multdiv_ctrl
  import multdiv_pkg::*;
#(
  parameter int unsigned MULT_LAT = MULT_LAT_DEF,
  parameter int unsigned DIV_LAT  = DIV_LAT_DEF,
  parameter int unsigned WIDTH    = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy,
  output logic [WIDTH-1:0] dp_opA,
  output logic [WIDTH-1:0] dp_opB,
  output logic             dp_ctrl_MULT,
  output logic             dp_ctrl_DIV,
  input  logic [WIDTH-1:0] dp_mult_result,
  input  logic             dp_mult_ovf,
  input  logic [WIDTH-1:0] dp_div_quot,
  input  logic             dp_div_except
);

  state_t           state, nextState;
  op_t              reqOp;
  logic             accept, divZero, capture, rdyNext;
  logic             pulseMultNext, pulseDivNext;
  logic             cntLoad, cntEn, cntZero;
  logic [CNT_W-1:0] cntLoadVal;

  multdiv_cnt uCnt (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (cntLoad),
    .en      (cntEn),
    .loadVal (cntLoadVal),
    .zero    (cntZero)
  );

  // Next-state and control decode; a new request overrides any in-flight work.
  // Divide-by-zero reloads the counter with zero so it rests at zero outside RUN.
  always_comb begin
    nextState     = state;
    reqOp         = ctrl_MULT ? OP_MULT : OP_DIV;
    accept        = ctrl_MULT | ctrl_DIV;
    divZero       = 1'b0;
    capture       = 1'b0;
    rdyNext       = 1'b0;
    pulseMultNext = 1'b0;
    pulseDivNext  = 1'b0;
    cntLoad       = 1'b0;
    cntLoadVal    = '0;
    cntEn         = (state == MULT_RUN) || (state == DIV_RUN);
    if (accept) begin
      cntLoad = 1'b1;
      if (reqOp == OP_MULT) begin
        nextState     = MULT_RUN;
        cntLoadVal    = latLoad(MULT_LAT);
        pulseMultNext = 1'b1;
      end else if (data_operandB == '0) begin
        divZero   = 1'b1;
        nextState = DONE;
        rdyNext   = 1'b1;
      end else begin
        nextState    = DIV_RUN;
        cntLoadVal   = latLoad(DIV_LAT);
        pulseDivNext = 1'b1;
      end
    end else begin
      unique case (state)
        MULT_RUN, DIV_RUN: begin
          if (cntZero) begin
            capture   = 1'b1;
            nextState = DONE;
            rdyNext   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // State and registered control outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      dp_ctrl_MULT   <= 1'b0;
      dp_ctrl_DIV    <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state          <= nextState;
      dp_ctrl_MULT   <= pulseMultNext;
      dp_ctrl_DIV    <= pulseDivNext;
      data_resultRDY <= rdyNext;
      busy           <= (nextState == MULT_RUN) || (nextState == DIV_RUN);
    end
  end

  // Operand latch and result capture/hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dp_opA         <= '0;
      dp_opB         <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else if (accept) begin
      dp_opA         <= data_operandA;
      dp_opB         <= data_operandB;
      data_result    <= '0;
      data_exception <= divZero;
    end else if (capture) begin
      if (state == MULT_RUN) begin
        data_result    <= dp_mult_result;
        data_exception <= dp_mult_ovf;
      end else begin
        data_result    <= dp_div_quot;
        data_exception <= dp_div_except;
      end
    end
  end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Scoreboard bench for multdiv_ctrl with behavioural datapath and reference model.
module tb_multdiv_ctrl;

  localparam int MULT_LAT = 33;
  localparam int DIV_LAT  = 33;

  typedef struct packed {
    logic [31:0] r;
    logic        e;
  } res_t;

  typedef struct {
    int          rdy;
    logic [31:0] res;
    logic        exc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_operandA, data_operandB;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY, busy;
  logic [31:0] dp_opA, dp_opB;
  logic        dp_ctrl_MULT, dp_ctrl_DIV;
  logic [31:0] dp_mult_result, dp_div_quot;
  logic        dp_mult_ovf, dp_div_except;

  int          nChecks = 0;
  int          nFail   = 0;
  int          cyc     = 0;
  bit          started = 0;
  exp_t        q[$];
  int          expMulPulse = -1, expDivPulse = -1;
  int          busyFrom = 0, busyTo = -1;
  logic [31:0] heldRes = '0, expOpA = '0, expOpB = '0;
  logic        heldExc = 1'b0;
  int          lastRdy = 0, reqCyc = 0;

  res_t        mR = '0, dR = '0;
  int          mCnt = 0, dCnt = 0;

  multdiv_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .WIDTH(32)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy),
    .dp_opA         (dp_opA),
    .dp_opB         (dp_opB),
    .dp_ctrl_MULT   (dp_ctrl_MULT),
    .dp_ctrl_DIV    (dp_ctrl_DIV),
    .dp_mult_result (dp_mult_result),
    .dp_mult_ovf    (dp_mult_ovf),
    .dp_div_quot    (dp_div_quot),
    .dp_div_except  (dp_div_except)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic res_t refMult(input logic [31:0] a, input logic [31:0] b);
    longint p;
    res_t   o;
    p   = longint'($signed(a)) * longint'($signed(b));
    o.r = p[31:0];
    o.e = (p != longint'($signed(o.r)));
    return o;
  endfunction

  function automatic res_t refDiv(input logic [31:0] a, input logic [31:0] b);
    longint qq;
    res_t   o;
    if (b == 32'd0) begin
      o.r = '0;
      o.e = 1'b1;
    end else begin
      qq  = longint'($signed(a)) / longint'($signed(b));
      o.r = qq[31:0];
      o.e = (qq > 64'sd2147483647);
    end
    return o;
  endfunction

  // Iterative datapath stand-ins: output is junk until their latency has elapsed.
  always @(posedge clk) begin
    if (dp_ctrl_MULT) begin
      mR   <= refMult(dp_opA, dp_opB);
      mCnt <= 1;
    end else if (mCnt > 0 && mCnt < 1000) begin
      mCnt <= mCnt + 1;
    end
    if (dp_ctrl_DIV) begin
      dR   <= refDiv(dp_opA, dp_opB);
      dCnt <= 1;
    end else if (dCnt > 0 && dCnt < 1000) begin
      dCnt <= dCnt + 1;
    end
  end

  assign dp_mult_result = (mCnt >= MULT_LAT - 1) ? mR.r : ~mR.r;
  assign dp_mult_ovf    = (mCnt >= MULT_LAT - 1) ? mR.e : ~mR.e;
  assign dp_div_quot    = (dCnt >= DIV_LAT - 1)  ? dR.r : ~dR.r;
  assign dp_div_except  = (dCnt >= DIV_LAT - 1)  ? dR.e : ~dR.e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each completion and checks per-cycle outputs.
  always @(negedge clk) begin
    if (started && reset_n) begin
      if (data_resultRDY) begin
        chk("rdyPending", 64'(q.size() > 0), 64'd1);
        if (q.size() > 0) begin
          exp_t e;
          e = q.pop_front();
          chk("rdyCycle", 64'(cyc), 64'(e.rdy));
          heldRes = e.res;
          heldExc = e.exc;
        end
      end else if (q.size() > 0 && cyc > q[0].rdy) begin
        chk("rdyMissing", 64'(cyc), 64'(q[0].rdy));
        void'(q.pop_front());
      end
      chk("result", 64'(data_result), 64'(heldRes));
      chk("exception", 64'(data_exception), 64'(heldExc));
      chk("busy", 64'(busy), 64'(cyc >= busyFrom && cyc <= busyTo));
      chk("pulseMult", 64'(dp_ctrl_MULT), 64'(cyc == expMulPulse));
      chk("pulseDiv", 64'(dp_ctrl_DIV), 64'(cyc == expDivPulse));
      chk("opA", 64'(dp_opA), 64'(expOpA));
      chk("opB", 64'(dp_opB), 64'(expOpB));
    end
  end

  task automatic waitCyc(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents one request for a single cycle and records what must follow.
  task automatic issue(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    res_t r;
    int   n;
    @(negedge clk);
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    data_operandA = a;
    data_operandB = b;
    @(posedge clk);
    #1;
    n      = cyc;
    reqCyc = n;
    q.delete();
    expOpA = a;
    expOpB = b;
    expMulPulse = -1;
    expDivPulse = -1;
    busyFrom    = n;
    if (m) begin
      r = refMult(a, b);
      q.push_back('{n + MULT_LAT, r.r, r.e});
      expMulPulse = n;
      busyTo      = n + MULT_LAT - 1;
      lastRdy     = n + MULT_LAT;
      heldExc     = 1'b0;
    end else if (b == 32'd0) begin
      q.push_back('{n, 32'd0, 1'b1});
      busyTo  = n - 1;
      lastRdy = n;
      heldExc = 1'b1;
    end else begin
      r = refDiv(a, b);
      q.push_back('{n + DIV_LAT, r.r, r.e});
      expDivPulse = n;
      busyTo      = n + DIV_LAT - 1;
      lastRdy     = n + DIV_LAT;
      heldExc     = 1'b0;
    end
    heldRes   = '0;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
  endtask

  task automatic chkAllZero(input string tag);
    chk({tag, "_result"}, 64'(data_result), 64'd0);
    chk({tag, "_exception"}, 64'(data_exception), 64'd0);
    chk({tag, "_rdy"}, 64'(data_resultRDY), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_opA"}, 64'(dp_opA), 64'd0);
    chk({tag, "_opB"}, 64'(dp_opB), 64'd0);
    chk({tag, "_pulseMult"}, 64'(dp_ctrl_MULT), 64'd0);
    chk({tag, "_pulseDiv"}, 64'(dp_ctrl_DIV), 64'd0);
  endtask

  initial begin
    reset_n       = 1'b0;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (3) @(posedge clk);
    #1;
    chkAllZero("reset");
    @(negedge clk);
    reset_n = 1'b1;
    started = 1;

    issue(1'b1, 1'b0, 32'd7, 32'd6);
    waitCyc(lastRdy + 3);
    issue(1'b0, 1'b1, -32'sd100, 32'd7);
    waitCyc(lastRdy + 6);
    issue(1'b0, 1'b1, 32'd5, 32'd0);
    waitCyc(lastRdy + 3);
    issue(1'b0, 1'b1, 32'd1000, 32'd3);
    waitCyc(reqCyc + 9);
    issue(1'b1, 1'b0, 32'd3, 32'd4);
    waitCyc(lastRdy + 2);
    issue(1'b1, 1'b1, 32'd9, 32'd11);
    waitCyc(lastRdy + 2);
    issue(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
    waitCyc(lastRdy);
    issue(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    waitCyc(lastRdy + 2);

    // Asynchronous reset between edges during a divide.
    issue(1'b0, 1'b1, 32'd77, 32'd5);
    waitCyc(reqCyc + 4);
    #2;
    reset_n = 1'b0;
    #1;
    chkAllZero("midReset");
    q.delete();
    expMulPulse = -1;
    expDivPulse = -1;
    busyTo      = -1;
    heldRes     = '0;
    heldExc     = 1'b0;
    expOpA      = '0;
    expOpB      = '0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    waitCyc(cyc + 45);

    for (int i = 0; i < 40; i++) begin
      logic        m, d;
      logic [31:0] a, b;
      int unsigned mode;
      m = 1'($urandom_range(0, 1));
      d = (!m) ? 1'b1 : 1'($urandom_range(0, 1));
      a = $urandom;
      b = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 2) == 0) begin
        a = a >>> $urandom_range(8, 24);
        b = b >>> $urandom_range(8, 24);
      end
      issue(m, d, a, b);
      mode = $urandom_range(0, 2);
      if (mode == 0) waitCyc(lastRdy + 1 + int'($urandom_range(0, 3)));
      else if (mode == 1) waitCyc(lastRdy);
      else waitCyc(reqCyc + int'($urandom_range(0, 34)));
    end
    waitCyc(lastRdy + 3);
    chk("queueDrained", 64'(q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
